// File: rtl/duty_ramp.sv
// duty_ramp: triangle-wave duty-cycle generator for the LED-breathing path.
// It steps a WIDTH-bit level up to full scale, optionally holds there, steps back
// down to 0, optionally holds there, and repeats. Each step is one accepted tick.
// Optional feature macro: DUTY_RAMP_GAMMA_EN. When it is defined, the output is
// squared for perceptual brightness and every output gains one cycle of latency.
module duty_ramp #(
    parameter int WIDTH    = 8,
    parameter int HOLD_TOP = 0,
    parameter int HOLD_BOT = 0
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             enable,
    input  logic             tick,
    output logic [WIDTH-1:0] dutyCycle,
    output logic             dir,
    output logic             peak,
    output logic             trough
);

    localparam int HOLD_MAX = (HOLD_TOP > HOLD_BOT) ? HOLD_TOP : HOLD_BOT;
    localparam int HCW      = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

    localparam logic [WIDTH-1:0] MAX          = '1;
    localparam logic [WIDTH-1:0] ZERO         = '0;
    localparam logic [HCW-1:0]   HOLD_TOP_CNT = HCW'(HOLD_TOP);
    localparam logic [HCW-1:0]   HOLD_BOT_CNT = HCW'(HOLD_BOT);
    localparam logic [HCW-1:0]   HOLD_LAST    = HCW'(1);

    typedef enum logic [1:0] {
        UP      = 2'd0,
        HOLD_HI = 2'd1,
        DOWN    = 2'd2,
        HOLD_LO = 2'd3
    } rampState_t;

    rampState_t       state;
    logic [WIDTH-1:0] level;
    logic [HCW-1:0]   holdCnt;
    logic             dirR;
    logic             peakR;
    logic             troughR;

    logic             accept;
    logic [WIDTH-1:0] levelInc;
    logic [WIDTH-1:0] levelDec;

    assign accept   = tick & enable;
    assign levelInc = level + WIDTH'(1);
    assign levelDec = level - WIDTH'(1);

    // Ramp state machine: level, hold counter, direction and turnaround pulses.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state   <= UP;
            level   <= '0;
            holdCnt <= '0;
            dirR    <= 1'b1;
            peakR   <= 1'b0;
            troughR <= 1'b0;
        end else begin
            peakR   <= 1'b0;
            troughR <= 1'b0;
            if (accept) begin
                case (state)
                    UP: begin
                        level <= levelInc;
                        if (levelInc == MAX) begin
                            peakR <= 1'b1;
                            if (HOLD_TOP == 0) begin
                                state <= DOWN;
                                dirR  <= 1'b0;
                            end else begin
                                state   <= HOLD_HI;
                                holdCnt <= HOLD_TOP_CNT;
                            end
                        end
                    end
                    HOLD_HI: begin
                        holdCnt <= holdCnt - HCW'(1);
                        if (holdCnt == HOLD_LAST) begin
                            state <= DOWN;
                            dirR  <= 1'b0;
                        end
                    end
                    DOWN: begin
                        level <= levelDec;
                        if (levelDec == ZERO) begin
                            troughR <= 1'b1;
                            if (HOLD_BOT == 0) begin
                                state <= UP;
                                dirR  <= 1'b1;
                            end else begin
                                state   <= HOLD_LO;
                                holdCnt <= HOLD_BOT_CNT;
                            end
                        end
                    end
                    HOLD_LO: begin
                        holdCnt <= holdCnt - HCW'(1);
                        if (holdCnt == HOLD_LAST) begin
                            state <= UP;
                            dirR  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= UP;
                        dirR  <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef DUTY_RAMP_GAMMA_EN
    // Square in 2*WIDTH bits; adding MAX before the shift keeps 1 -> 1 and MAX -> MAX.
    logic [2*WIDTH-1:0] levelSq;

    assign levelSq = ({{WIDTH{1'b0}}, level} * {{WIDTH{1'b0}}, level})
                   + {{WIDTH{1'b0}}, MAX};

    // Output stage: registered gamma value, with the flags delayed to stay aligned.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            dutyCycle <= '0;
            dir       <= 1'b1;
            peak      <= 1'b0;
            trough    <= 1'b0;
        end else begin
            dutyCycle <= levelSq[2*WIDTH-1:WIDTH];
            dir       <= dirR;
            peak      <= peakR;
            trough    <= troughR;
        end
    end
`else
    // Linear output: the level register drives the PWM input directly.
    assign dutyCycle = level;
    assign dir       = dirR;
    assign peak      = peakR;
    assign trough    = troughR;
`endif

endmodule

// File: tb/tb_duty_ramp.sv
// Directed bench for duty_ramp: one default instance and one with top/bottom holds.
module tb_duty_ramp;

`ifdef DUTY_RAMP_GAMMA_EN
    localparam bit GAMMA = 1'b1;
    localparam int LAT   = 2;
`else
    localparam bit GAMMA = 1'b0;
    localparam int LAT   = 1;
`endif

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       enable = 1'b1;
    logic       tick = 1'b0;
    logic [7:0] duty0, duty1;
    logic       dir0, dir1, peak0, peak1, trough0, trough1;

    int nChecks = 0;
    int nFails  = 0;

    duty_ramp #(.WIDTH(8), .HOLD_TOP(0), .HOLD_BOT(0)) dut0 (
        .clk(clk), .nRst(nRst), .enable(enable), .tick(tick),
        .dutyCycle(duty0), .dir(dir0), .peak(peak0), .trough(trough0)
    );

    duty_ramp #(.WIDTH(8), .HOLD_TOP(3), .HOLD_BOT(2)) dut1 (
        .clk(clk), .nRst(nRst), .enable(enable), .tick(tick),
        .dutyCycle(duty1), .dir(dir1), .peak(peak1), .trough(trough1)
    );

    always #5 clk = ~clk;

    // Expected output for a given level (linear, or squared with rounding up of endpoints).
    function automatic logic [7:0] expDuty(input int l);
        int v;
        v = GAMMA ? (l * l + 255) / 256 : l;
        return v[7:0];
    endfunction

    // Default ramp after t ticks from reset (period 510).
    function automatic logic [10:0] exp0(input int t);
        int  l;
        bit  d;
        l = (t <= 255) ? t : ((t <= 510) ? 510 - t : t - 510);
        d = (t < 255) ? 1'b1 : ((t < 510) ? 1'b0 : 1'b1);
        return {expDuty(l), d, (t == 255), (t == 510)};
    endfunction

    // Ramp with HOLD_TOP=3, HOLD_BOT=2 after t ticks from reset (period 515).
    function automatic logic [10:0] exp1(input int t);
        int  l;
        bit  d;
        if (t <= 255)      l = t;
        else if (t <= 258) l = 255;
        else if (t <= 513) l = 513 - t;
        else if (t <= 515) l = 0;
        else               l = t - 515;
        d = (t < 258) ? 1'b1 : ((t < 515) ? 1'b0 : 1'b1);
        return {expDuty(l), d, (t == 255), (t == 513)};
    endfunction

    task automatic doReset;
        @(negedge clk);
        nRst   = 1'b0;
        tick   = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        nRst = 1'b1;
    endtask

    // One isolated tick, returning at the negedge where its result is visible.
    task automatic doTick;
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (LAT - 1) @(negedge clk);
    endtask

    task automatic test_reset;
        doReset();
        @(negedge clk);
        nChecks++;
        if ({duty0, dir0, peak0, trough0} !== {8'd0, 1'b1, 1'b0, 1'b0}) begin
            nFails++;
            $display("FAIL reset_dut0 got=%h exp=%h", {duty0, dir0, peak0, trough0}, {8'd0, 3'b100});
        end
        nChecks++;
        if ({duty1, dir1, peak1, trough1} !== {8'd0, 1'b1, 1'b0, 1'b0}) begin
            nFails++;
            $display("FAIL reset_dut1 got=%h exp=%h", {duty1, dir1, peak1, trough1}, {8'd0, 3'b100});
        end
    endtask

    task automatic test_ramp;
        logic [10:0] e;
        doReset();
        for (int t = 1; t <= 511; t++) begin
            doTick();
            e = exp0(t);
            nChecks++;
            if ({duty0, dir0, peak0, trough0} !== e) begin
                nFails++;
                $display("FAIL ramp t=%0d duty=%0d dir=%b pk=%b tr=%b exp duty=%0d dir=%b pk=%b tr=%b",
                         t, duty0, dir0, peak0, trough0, e[10:3], e[2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_hold;
        logic [10:0] e;
        doReset();
        for (int t = 1; t <= 516; t++) begin
            doTick();
            e = exp1(t);
            nChecks++;
            if ({duty1, dir1, peak1, trough1} !== e) begin
                nFails++;
                $display("FAIL hold t=%0d duty=%0d dir=%b pk=%b tr=%b exp duty=%0d dir=%b pk=%b tr=%b",
                         t, duty1, dir1, peak1, trough1, e[10:3], e[2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_enable_freeze;
        doReset();
        repeat (100) doTick();
        enable = 1'b0;
        tick   = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            nChecks++;
            if ({duty0, dir0, peak0, trough0} !== {expDuty(100), 3'b100}) begin
                nFails++;
                $display("FAIL freeze c=%0d got duty=%0d exp=%0d", c, duty0, expDuty(100));
            end
        end
        tick   = 1'b0;
        enable = 1'b1;
        doTick();
        nChecks++;
        if ({duty0, dir0} !== {expDuty(101), 1'b1}) begin
            nFails++;
            $display("FAIL resume got duty=%0d dir=%b exp duty=%0d dir=1", duty0, dir0, expDuty(101));
        end
        nChecks++;
        if ({duty1, dir1} !== {expDuty(101), 1'b1}) begin
            nFails++;
            $display("FAIL resume_hold got duty=%0d dir=%b exp duty=%0d dir=1", duty1, dir1, expDuty(101));
        end
    endtask

    task automatic test_async_reset;
        doReset();
        repeat (257) doTick();
        nChecks++;
        if ({duty1, dir1} !== {expDuty(255), 1'b1}) begin
            nFails++;
            $display("FAIL pre_reset_hold got duty=%0d dir=%b exp duty=%0d dir=1", duty1, dir1, expDuty(255));
        end
        #2;
        nRst = 1'b0;
        #1;
        nChecks++;
        if ({duty1, dir1, peak1, trough1} !== {8'd0, 3'b100}) begin
            nFails++;
            $display("FAIL async_reset_dut1 got=%h exp=%h", {duty1, dir1, peak1, trough1}, {8'd0, 3'b100});
        end
        nChecks++;
        if ({duty0, dir0, peak0, trough0} !== {8'd0, 3'b100}) begin
            nFails++;
            $display("FAIL async_reset_dut0 got=%h exp=%h", {duty0, dir0, peak0, trough0}, {8'd0, 3'b100});
        end
        @(negedge clk);
        nRst = 1'b1;
        doTick();
        nChecks++;
        if ({duty1, dir1, peak1, trough1} !== {expDuty(1), 3'b100}) begin
            nFails++;
            $display("FAIL after_reset_tick got duty=%0d exp=%0d", duty1, expDuty(1));
        end
    endtask

    task automatic test_back_to_back;
        doReset();
        @(negedge clk);
        tick = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            nChecks++;
            if (duty0 !== expDuty(i - (LAT - 1))) begin
                nFails++;
                $display("FAIL back_to_back i=%0d got=%0d exp=%0d", i, duty0, expDuty(i - (LAT - 1)));
            end
        end
        tick = 1'b0;
        @(negedge clk);
    endtask

`ifdef DUTY_RAMP_GAMMA_EN
    task automatic test_gamma;
        doReset();
        repeat (128) doTick();
        nChecks++;
        if (duty0 !== 8'd64) begin
            nFails++;
            $display("FAIL gamma_128 got=%0d exp=64", duty0);
        end
        repeat (127) doTick();
        nChecks++;
        if ({duty0, peak0} !== {8'd255, 1'b1}) begin
            nFails++;
            $display("FAIL gamma_255 got duty=%0d pk=%b exp duty=255 pk=1", duty0, peak0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ramp();
        test_hold();
        test_enable_freeze();
        test_async_reset();
        test_back_to_back();
`ifdef DUTY_RAMP_GAMMA_EN
        test_gamma();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
